pool_line_feeder: RTL and testbench

POOL_LINE_FEEDER -- requirements
Module: pool_line_feeder

---
 rtl/pool_line_feeder.sv | 93 +++++++++
 tb/tb_pool_line_feeder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pool_line_feeder.sv
// Line-buffer feeder for a 2x2 max-pool: pairs each odd-row pixel with the even-row pixel above it.
// Optional frame sync input (sof) is enabled by defining POOL_FEEDER_FRAME_SYNC_EN.
module pool_line_feeder #(
  parameter int BIT_WIDTH = 32,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] in_data,
`ifdef POOL_FEEDER_FRAME_SYNC_EN
  input  logic                        sof,
`endif
  output logic                        pool_en,
  output logic signed [BIT_WIDTH-1:0] pool_in1,
  output logic signed [BIT_WIDTH-1:0] pool_in2,
  output logic                        pool_valid,
  output logic                        frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic          last_col, last_row;
  logic          sof_i;
  logic          src_odd, src_last;
  logic signed [BIT_WIDTH-1:0] linebuf [IMG_W];

`ifdef POOL_FEEDER_FRAME_SYNC_EN
  assign sof_i = sof;
`else
  assign sof_i = 1'b0;
`endif

  // A frame-start pixel is handled as if the counters already sat at (0,0).
  // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
  always_comb begin
    eff_col  = sof_i ? '0 : col;
    eff_row  = sof_i ? '0 : row;
    last_col = (eff_col == CW'(IMG_W - 1));
    last_row = (eff_row == RW'(IMG_H - 1));
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      pool_en    <= 1'b0;
      pool_in1   <= '0;
      pool_in2   <= '0;
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      src_odd    <= 1'b0;
      src_last   <= 1'b0;
    end else begin
      pool_en <= 1'b0;
      if (in_valid) begin
        if (eff_row[0]) begin
          pool_in1 <= linebuf[eff_col];
          pool_in2 <= in_data;
          pool_en  <= 1'b1;
          src_odd  <= eff_col[0];
          src_last <= last_row && last_col;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : eff_row + 1'b1;
        end else begin
          col <= eff_col + 1'b1;
          row <= eff_row;
        end
      end else if (sof_i) begin
        col <= '0;
        row <= '0;
      end
      // The right-hand column of a pair completes the window one cycle later,
      // unless a new frame has just started and aborted it.
      pool_valid <= pool_en && src_odd && !(sof_i && in_valid);
      frame_done <= pool_en && src_odd && src_last && !(sof_i && in_valid);
    end
  end

  // NOTE: the line buffer is deliberately not reset; row restarts even, so it is rewritten before any read.
  always_ff @(posedge clk) begin
    if (in_valid && !eff_row[0])
      linebuf[eff_col] <= in_data;
  end

endmodule

// File: tb/tb_pool_line_feeder.sv
// Self-checking bench for pool_line_feeder on a 4x4 frame, with a frame-position model and a downstream max-pool.
// Exercises the sof input when POOL_FEEDER_FRAME_SYNC_EN is defined.
module tb_pool_line_feeder;
  localparam int BW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [BW-1:0] in_data;
  logic                 sof;
  logic                 pool_en, pool_valid, frame_done;
  logic signed [BW-1:0] pool_in1, pool_in2;

  pool_line_feeder #(.BIT_WIDTH(BW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef POOL_FEEDER_FRAME_SYNC_EN
    .sof(sof),
`endif
    .pool_en(pool_en), .pool_in1(pool_in1), .pool_in2(pool_in2),
    .pool_valid(pool_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Expectations keyed by the clock edge after which they must be visible.
  bit     exp_en  [int];
  longint exp_i1  [int];
  longint exp_i2  [int];
  bit     exp_pv  [int];
  bit     exp_fd  [int];
  longint exp_max [int];
  longint img [H][W];
  int     mr = 0, mc = 0;

  longint mx_q [$];
  int     fd_cnt = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint max2(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  // Drive one cycle of input and record what the frame position implies for the outputs.
  task automatic pix(input bit v, input longint d, input bit s);
    int k;
    @(posedge clk); #1;
    in_valid = v;
    in_data  = d[BW-1:0];
    sof      = s;
    k = edge_n + 1;
    if (s && v) begin
      mr = 0; mc = 0;
      exp_pv.delete(k); exp_fd.delete(k); exp_max.delete(k);
    end else if (s) begin
      mr = 0; mc = 0;
    end
    if (v) begin
      img[mr][mc] = d;
      if (mr % 2 == 1) begin
        exp_en[k] = 1'b1;
        exp_i1[k] = img[mr-1][mc];
        exp_i2[k] = d;
        if (mc % 2 == 1) begin
          exp_pv[k+1]  = 1'b1;
          exp_fd[k+1]  = (mr == H-1) && (mc == W-1);
          exp_max[k+1] = max2(max2(img[mr-1][mc-1], img[mr-1][mc]), max2(img[mr][mc-1], d));
        end
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 0, 1'b0);
  endtask

  task automatic frame(input longint base, input longint stp, input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      pix(1'b1, base + stp*i, 1'b0);
      if (gaps) pix(1'b0, 0, 1'b0);
    end
  endtask

  task automatic check_list(input string nm, input longint e[$], input int fd_exp);
    check({nm, "_count"}, mx_q.size(), e.size());
    for (int i = 0; i < e.size() && i < mx_q.size(); i++)
      check($sformatf("%s_max%0d", nm, i), mx_q[i], e[i]);
    check({nm, "_frame_done"}, fd_cnt, fd_exp);
    mx_q.delete();
    fd_cnt = 0;
  endtask

  // Compare process, plus a behavioural downstream 2x2 max-pool fed by the DUT outputs.
  longint hold1 = 0, hold2 = 0, pair_prev = 0, pair_cur = 0;
  always @(negedge clk) begin
    int n;
    n = edge_n;
    if (!rst_n) begin
      hold1 = 0; hold2 = 0;
      check("rst_pool_en", pool_en, 0);
      check("rst_pool_in1", pool_in1, 0);
      check("rst_pool_in2", pool_in2, 0);
      check("rst_pool_valid", pool_valid, 0);
      check("rst_frame_done", frame_done, 0);
    end else begin
      if (exp_en.exists(n)) begin
        hold1 = exp_i1[n];
        hold2 = exp_i2[n];
      end
      check("pool_en", pool_en, exp_en.exists(n));
      check("pool_in1", pool_in1, hold1);
      check("pool_in2", pool_in2, hold2);
      check("pool_valid", pool_valid, exp_pv.exists(n));
      check("frame_done", frame_done, exp_fd.exists(n) ? exp_fd[n] : 1'b0);
      if (pool_valid) begin
        mx_q.push_back(max2(pair_prev, pair_cur));
        if (exp_max.exists(n)) check("max_out", max2(pair_prev, pair_cur), exp_max[n]);
        if (frame_done) fd_cnt++;
      end
      if (pool_en) begin
        pair_prev = pair_cur;
        pair_cur  = max2(pool_in1, pool_in2);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sof = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    frame(0, 1, 1'b0);
    idle(4);
    check_list("b2b", '{5, 7, 13, 15}, 1);

    frame(0, 1, 1'b1);
    idle(4);
    check_list("gaps", '{5, 7, 13, 15}, 1);

    frame(-1, -1, 1'b0);
    idle(4);
    check_list("neg", '{-1, -3, -9, -11}, 1);

    for (int i = 0; i <= 6; i++) pix(1'b1, i, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    foreach (exp_pv[key]) if (key > edge_n) exp_pv.delete(key);
    foreach (exp_fd[key]) if (key > edge_n) exp_fd.delete(key);
    foreach (exp_en[key]) if (key > edge_n) exp_en.delete(key);
    mr = 0; mc = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mx_q.delete(); fd_cnt = 0;
    frame(100, 1, 1'b0);
    idle(4);
    check_list("reset", '{105, 107, 113, 115}, 1);

    frame(0, 1, 1'b0);
    frame(200, 1, 1'b0);
    idle(4);
    check_list("two", '{5, 7, 13, 15, 205, 207, 213, 215}, 2);

`ifdef POOL_FEEDER_FRAME_SYNC_EN
    for (int i = 0; i <= 8; i++) pix(1'b1, i, 1'b0);
    pix(1'b1, 300, 1'b1);
    for (int i = 1; i < W*H; i++) pix(1'b1, 300 + i, 1'b0);
    idle(4);
    check_list("sof9", '{5, 7, 305, 307, 313, 315}, 1);

    for (int i = 0; i <= 7; i++) pix(1'b1, i, 1'b0);
    pix(1'b1, 300, 1'b1);
    for (int i = 1; i < W*H; i++) pix(1'b1, 300 + i, 1'b0);
    idle(4);
    check_list("sof_cancel", '{5, 305, 307, 313, 315}, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
